// File: rtl/systolic_row_sched_if.sv
// Activation stream, systolic chain head/tail and result stream for one row scheduler.
// The master side is the scheduler; the slave side is the source, array and sink.
interface systolic_row_sched_if #(
    parameter int I_WIDTH    = 8,
    parameter int P_WIDTH    = 20,
    parameter int CTRL_WIDTH = 2
);
    logic                  iact_valid;
    logic [I_WIDTH-1:0]    iact_data;
    logic                  iact_ready;
    logic [CTRL_WIDTH-1:0] arr_ctrl_out;
    logic [I_WIDTH-1:0]    arr_iact_out;
    logic [P_WIDTH-1:0]    arr_psum_in;
    logic                  psum_valid;
    logic [P_WIDTH-1:0]    psum_data;
    logic                  psum_ready;

    modport master (
        input  iact_valid, iact_data, arr_psum_in, psum_ready,
        output iact_ready, arr_ctrl_out, arr_iact_out, psum_valid, psum_data
    );

    modport slave (
        output iact_valid, iact_data, arr_psum_in, psum_ready,
        input  iact_ready, arr_ctrl_out, arr_iact_out, psum_valid, psum_data
    );
endinterface

// File: rtl/systolic_row_sched.sv
// Streams a vector job into the head of a systolic row, waits out the wavefront
// skew, then returns the tail partial sum on a valid/ready port.
module systolic_row_sched #(
    parameter int I_WIDTH    = 8,
    parameter int P_WIDTH    = 20,
    parameter int CTRL_WIDTH = 2,
    parameter int NUM_PE     = 4,
    parameter int PE_LAT     = 1,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] vec_len,
    output logic                 busy,
    output logic                 done,
    systolic_row_sched_if.master bus
);
    localparam int DRAIN_CYC = NUM_PE + PE_LAT;
    localparam int DW        = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    logic [1:0]            state;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [DW-1:0]         dcnt;
    logic [CTRL_WIDTH-1:0] elem_ctrl;
    logic                  accept;

    always_comb begin
        busy           = (state != S_IDLE);
        bus.iact_ready = (state == S_STREAM) && (cnt < len);
        accept         = bus.iact_valid && bus.iact_ready;
        // bit0 marks a live element, bit1 tells the PEs to restart accumulation
        elem_ctrl      = '0;
        elem_ctrl[0]   = 1'b1;
        elem_ctrl[1]   = (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            len              <= '0;
            cnt              <= '0;
            dcnt             <= '0;
            done             <= 1'b0;
            bus.arr_ctrl_out <= '0;
            bus.arr_iact_out <= '0;
            bus.psum_valid   <= 1'b0;
            bus.psum_data    <= '0;
        end else begin
            done             <= 1'b0;
            bus.arr_ctrl_out <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (vec_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            len   <= vec_len;
                            cnt   <= '0;
                            state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        bus.arr_iact_out <= bus.iact_data;
                        bus.arr_ctrl_out <= elem_ctrl;
                        cnt              <= cnt + LEN_WIDTH'(1);
                        // compare before increment so a full-scale len never wraps
                        if (cnt == len - LEN_WIDTH'(1)) begin
                            state <= S_DRAIN;
                            dcnt  <= DRAIN_INIT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (dcnt == '0) begin
                        bus.psum_data  <= bus.arr_psum_in;
                        bus.psum_valid <= 1'b1;
                        state          <= S_OUT;
                    end else begin
                        dcnt <= dcnt - DW'(1);
                    end
                end
                S_OUT: begin
                    if (bus.psum_ready) begin
                        bus.psum_valid <= 1'b0;
                        done           <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
